// File: rtl/im_boot_loader_if.sv
// Byte-stream ingress and instruction-memory write bus for the boot loader.
// master: stream source / memory side; slave: the loader itself.
interface im_boot_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output im_we,
        output im_addr,
        output im_wdata
    );
endinterface

// File: rtl/im_boot_loader.sv
// Boot loader: parses A5/LEN/payload/CSUM frames, writes big-endian words
// to instruction memory and raises cpu_run once a verified image is loaded.
// Ports: clk, rst (async active-low), bus (stream in + IM write port),
// cpu_run, err (sticky), words_loaded.
module im_boot_loader #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    im_boot_loader_if.slave   bus,
    output logic              cpu_run,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        LEN_H,
        LEN_L,
        DATA,
        WRITE,
        CSUM,
        DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [7:0]    len_h;
    logic [15:0]   len;
    logic [31:0]   sr;
    logic [7:0]    acc;
    logic [1:0]    byte_cnt;
    logic [TW-1:0] idle_cnt;

    logic          xfer;
    logic          hdr;
    logic          err_set;
    logic          cnt_st;
    logic          to_hit;
    logic [15:0]   n_full;

    assign xfer   = bus.in_valid & bus.in_ready;
    assign n_full = {len_h, bus.in_data};

    always_comb begin
        state_n = state;
        hdr     = 1'b0;
        err_set = 1'b0;
        cnt_st  = (state == LEN_H) || (state == LEN_L) ||
                  (state == DATA)  || (state == CSUM);
        to_hit  = cnt_st && !xfer &&
                  (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
        case (state)
            IDLE: begin
                if (xfer && bus.in_data == 8'hA5) begin
                    hdr     = 1'b1;
                    state_n = LEN_H;
                end
            end
            LEN_H: begin
                if (xfer) state_n = LEN_L;
            end
            LEN_L: begin
                if (xfer) begin
                    if (32'(n_full) > (32'd1 << ADDR_W)) begin
                        err_set = 1'b1;
                        state_n = IDLE;
                    end else if (n_full == 16'd0) begin
                        state_n = CSUM;
                    end else begin
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer && byte_cnt == 2'd3) state_n = WRITE;
            end
            WRITE: begin
                if (32'(words_loaded) + 32'd1 == 32'(len))
                    state_n = CSUM;
                else
                    state_n = DATA;
            end
            CSUM: begin
                if (xfer) begin
                    if (bus.in_data == acc) begin
                        state_n = DONE;
                    end else begin
                        err_set = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            DONE: begin
                if (xfer && bus.in_data == 8'hA5) begin
                    hdr     = 1'b1;
                    state_n = LEN_H;
                end
            end
            default: state_n = IDLE;
        endcase
        if (to_hit) begin
            err_set = 1'b1;
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Handshake/status outputs are registered from the next state so
    // they are clean flops that reset to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.in_ready <= 1'b0;
            bus.im_we    <= 1'b0;
            cpu_run      <= 1'b0;
        end else begin
            bus.in_ready <= (state_n != WRITE);
            bus.im_we    <= (state_n == WRITE);
            cpu_run      <= (state_n == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err          <= 1'b0;
            words_loaded <= '0;
            bus.im_addr  <= '0;
            bus.im_wdata <= '0;
            len_h        <= '0;
            len          <= '0;
            sr           <= '0;
            acc          <= '0;
            byte_cnt     <= '0;
            idle_cnt     <= '0;
        end else begin
            if (hdr) begin
                err          <= 1'b0;
                words_loaded <= '0;
                acc          <= '0;
                byte_cnt     <= '0;
            end else if (err_set) begin
                err <= 1'b1;
            end

            if (state == LEN_H && xfer) len_h <= bus.in_data;
            if (state == LEN_L && xfer) len   <= n_full;

            if (state == DATA && xfer) begin
                sr       <= {sr[23:0], bus.in_data};
                acc      <= acc ^ bus.in_data;
                byte_cnt <= byte_cnt + 2'd1;
                // Latch address/word on the 4th byte so they are valid
                // during WRITE and hold until the next word.
                if (byte_cnt == 2'd3) begin
                    bus.im_addr  <= words_loaded[ADDR_W-1:0];
                    bus.im_wdata <= {sr[23:0], bus.in_data};
                end
            end

            if (state == WRITE) words_loaded <= words_loaded + 1'b1;

            // WRITE cycles neither count nor clear the idle timer.
            if (state != WRITE) begin
                if (!cnt_st || xfer || to_hit) idle_cnt <= '0;
                else                           idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_im_boot_loader.sv
// Directed self-checking bench for im_boot_loader.
// Drives framed byte streams and checks writes, status and reset.
module tb_im_boot_loader;
    localparam int ADDR_W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cpu_run;
    logic            err;
    logic [ADDR_W:0] words_loaded;

    int vec  = 0;
    int miss = 0;

    logic [ADDR_W-1:0] wr_a[$];
    logic [31:0]       wr_d[$];

    im_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    im_boot_loader #(
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .cpu_run(cpu_run),
        .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.im_we === 1'b1) begin
            wr_a.push_back(bus.im_addr);
            wr_d.push_back(bus.im_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves in_valid high so back-to-back calls stream continuously.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            vec++;
            miss++;
            $error("FAIL ready_wait observed=0 expected=1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    logic [7:0] good[12] = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00,
                             8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
    logic [7:0] one[8]   = '{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD,
                             8'hBE, 8'hEF, 8'h22};

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        // Reset state
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_im_we", 32'(bus.im_we), 0);
        chk("rst_cpu_run", 32'(cpu_run), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_words", 32'(words_loaded), 0);
        #5 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(bus.in_ready), 1);

        // 1: good two-word frame
        foreach (good[i]) send(good[i]);
        idle();
        chk("t1_cpu_run", 32'(cpu_run), 1);
        chk("t1_err", 32'(err), 0);
        chk("t1_words", 32'(words_loaded), 2);
        chk("t1_nwr", 32'(wr_a.size()), 2);
        if (wr_a.size() == 2) begin
            chk("t1_a0", 32'(wr_a[0]), 0);
            chk("t1_d0", wr_d[0], 32'h20080005);
            chk("t1_a1", 32'(wr_a[1]), 1);
            chk("t1_d1", wr_d[1], 32'h2009000A);
        end

        // 2: bad checksum, starting with a reload from DONE
        wr_a.delete();
        wr_d.delete();
        send(8'hA5);
        chk("t2_reload_run", 32'(cpu_run), 0);
        for (int i = 1; i < 11; i++) send(good[i]);
        send(8'h0F);
        idle();
        chk("t2_err", 32'(err), 1);
        chk("t2_cpu_run", 32'(cpu_run), 0);
        chk("t2_nwr", 32'(wr_a.size()), 2);
        chk("t2_idle_ready", 32'(bus.in_ready), 1);
        foreach (good[i]) send(good[i]);
        idle();
        chk("t2_err_clr", 32'(err), 0);
        chk("t2_rerun", 32'(cpu_run), 1);

        // 3: oversized length (257 words)
        wr_a.delete();
        wr_d.delete();
        send(8'hA5);
        send(8'h01);
        chk("t3_err_pre", 32'(err), 0);
        send(8'h01);
        idle();
        chk("t3_err", 32'(err), 1);
        chk("t3_cpu_run", 32'(cpu_run), 0);
        send(8'h00);
        send(8'h11);
        idle();
        chk("t3_err_hold", 32'(err), 1);
        chk("t3_words", 32'(words_loaded), 0);
        chk("t3_nwr", 32'(wr_a.size()), 0);

        // 4: timeout after header
        send(8'hA5);
        idle();
        chk("t4_err_clr", 32'(err), 0);
        repeat (999) @(posedge clk);
        #1;
        chk("t4_err_999", 32'(err), 0);
        @(posedge clk);
        #1;
        chk("t4_err_1000", 32'(err), 1);
        send(8'h00);
        idle();
        chk("t4_idle_err", 32'(err), 1);

        // 5: continuous valid through a one-word frame
        wr_a.delete();
        wr_d.delete();
        for (int i = 0; i < 7; i++) send(one[i]);
        chk("t5_wr_ready", 32'(bus.in_ready), 0);
        chk("t5_wr_we", 32'(bus.im_we), 1);
        chk("t5_wr_addr", 32'(bus.im_addr), 0);
        chk("t5_wr_data", bus.im_wdata, 32'hDEADBEEF);
        send(one[7]);
        idle();
        chk("t5_cpu_run", 32'(cpu_run), 1);
        chk("t5_words", 32'(words_loaded), 1);
        chk("t5_nwr", 32'(wr_a.size()), 1);
        chk("t5_hold_data", bus.im_wdata, 32'hDEADBEEF);

        // 6: reload then asynchronous reset mid-DATA
        wr_a.delete();
        wr_d.delete();
        send(8'hA5);
        chk("t6_run_fall", 32'(cpu_run), 0);
        send(8'h00);
        send(8'h02);
        send(8'h11);
        send(8'h22);
        idle();
        #2 rst = 1'b0;
        #1;
        chk("t6_ready", 32'(bus.in_ready), 0);
        chk("t6_we", 32'(bus.im_we), 0);
        chk("t6_addr", 32'(bus.im_addr), 0);
        chk("t6_data", bus.im_wdata, 0);
        chk("t6_run", 32'(cpu_run), 0);
        chk("t6_err", 32'(err), 0);
        chk("t6_words", 32'(words_loaded), 0);
        #4 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_nwr", 32'(wr_a.size()), 0);
        foreach (good[i]) send(good[i]);
        idle();
        chk("t6_recover", 32'(cpu_run), 1);
        chk("t6_recover_nwr", 32'(wr_a.size()), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/im_boot_loader.md
Name: im_boot_loader

Overview:
Upstream boot stage for the single-cycle MIPS core. It receives a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes those words into instruction memory through a dedicated write port. It holds the core halted until a complete, checksum-verified image is loaded, then asserts cpu_run so the integration top releases the core's reset.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words.
TIMEOUT_CYCLES, 1000, number of idle cycles allowed between accepted bytes mid-frame before the frame is aborted.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset.
in_data  input  8  stream byte.
in_valid  input  1  in_data is valid.
in_ready  output  1  loader can accept a byte; a byte is transferred when in_valid & in_ready are both high at a rising edge.
im_we  output  1  instruction-memory write enable, one-cycle pulse per word.
im_addr  output  ADDR_W  word address of the write.
im_wdata  output  32  instruction word being written.
cpu_run  output  1  1 = image valid, core may run; 0 = hold core in reset.
err  output  1  sticky frame-error flag.
words_loaded  output  ADDR_W+1  number of words written in the current or last frame.

Behaviour:
- Frame format: header 0xA5, then LEN_H, LEN_L (16-bit word count N, big-endian), then N*4 payload bytes (each word MSB first), then CSUM.
- CSUM is the XOR of all payload bytes only. The header and length bytes are excluded.
- Reset (rst=0, asynchronous): state IDLE, in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_run=0, err=0, words_loaded=0, all counters and XOR accumulator cleared. Instruction-memory contents are untouched.
- After reset is released, in_ready follows the state rule below from the next cycle.
- States: IDLE, LEN_H, LEN_L, DATA, WRITE, CSUM, DONE.
- in_ready is 1 in IDLE, LEN_H, LEN_L, DATA, CSUM and DONE. It is 0 in WRITE.
- IDLE: an accepted 0xA5 goes to LEN_H. It clears err, words_loaded, the XOR accumulator and the byte counter. Any other accepted byte is discarded.
- LEN_H: the accepted byte is stored as the upper length byte; go to LEN_L.
- LEN_L: the accepted byte completes N.
  - N > 2^ADDR_W: set err and go to IDLE.
  - N == 0: go to CSUM (expected CSUM is 0x00).
  - Otherwise go to DATA.
- DATA: each accepted byte is shifted into a 32-bit register from the MSB side and XORed into the accumulator. A 2-bit byte counter counts the bytes; the 4th byte goes to WRITE.
- WRITE (exactly 1 cycle):
  - im_we=1, im_addr = current word index, im_wdata = assembled word.
  - words_loaded and the word index increment at the end of the cycle.
  - Next state is CSUM if the new index equals N, otherwise DATA.
  - im_addr and im_wdata hold their value outside WRITE; im_we is 0 outside WRITE.
- CSUM: if the accepted byte equals the accumulator, go to DONE with cpu_run=1 from the next cycle. Otherwise set err and go to IDLE with cpu_run=0.
- DONE: cpu_run stays 1.
  - An accepted 0xA5 starts a reload: cpu_run goes to 0 on the same edge, the state goes to LEN_H and the counters clear as in IDLE.
  - Other accepted bytes are ignored.
- Timeout: in LEN_H, LEN_L, DATA and CSUM, an idle counter increments each cycle with no transfer and clears on each transfer. When it reaches TIMEOUT_CYCLES: set err, go to IDLE, clear the counter. WRITE cycles do not count.
- Words written before an error remain in memory; cpu_run stays 0 until a good frame completes.
- Reset asserted mid-frame aborts immediately. Any word whose WRITE cycle has not occurred is not written.
- Nothing is written beyond address 2^ADDR_W-1, because the length check rejects oversized frames.

Test Plan:
1. Good frame, bytes A5 00 02 20 08 00 05 20 09 00 0A 0E -> im_we pulses at addr 0 with 0x20080005 and at addr 1 with 0x2009000A; cpu_run=1 the cycle after CSUM; err=0; words_loaded=2.
2. Same frame with CSUM 0x0F -> both words are written; err=1; cpu_run=0; state IDLE; a following good frame clears err and sets cpu_run=1.
3. ADDR_W=8, bytes A5 01 01 -> err=1 on the LEN_L edge; no im_we pulse; bytes 00 11 in IDLE are ignored.
4. Send A5 then hold in_valid=0 -> err=1 exactly TIMEOUT_CYCLES (1000) cycles after the header transfer; state IDLE.
5. in_valid held high continuously through a 1-word frame -> in_ready=0 for the single WRITE cycle; no byte is lost or duplicated; im_wdata is correct.
6. From DONE send A5 -> cpu_run falls on the next edge; drive rst low mid-DATA -> all outputs are 0 immediately, asynchronously, without waiting for a clock edge.
